mix_columns_pipe: RTL and testbench
===================================

Name: mix_columns_pipe

Overview:
Parametrised, pipelined MixColumns / InvMixColumns engine that processes NCOL 32-bit columns per beat. At NCOL=4 this is one full 128-bit AES state per beat. Each beat carries its own mode: forward, inverse, or bypass. Bypass covers the final round, which has no MixColumns. The block sits between ShiftRows/SubBytes and AddRoundKey in the round datapath and uses a valid/ready handshake with full backpressure.

Parameters:
NCOL, 4, number of 32-bit columns per beat (1..4); data width W = 32*NCOL.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  W  state in; column 0 = in_data[W-1:W-32]; within a column, byte s0 = MSB
in_inv  input  1  1 = InvMixColumns, 0 = MixColumns
in_bypass  input  1  1 = pass data unchanged (overrides in_inv)
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
out_data  output  W  transformed state, same packing as in_data
busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- Reset: asserting rst clears both stage-valid flags immediately, regardless of clk.
  - After reset: out_valid=0, busy=0, out_data=0, in_ready=1.
  - Any beats in flight are discarded; there is no partial output.
- Pipeline has two register stages; latency is exactly 2 cycles from input handshake to out_valid, with no stall.
  - Stage 1 registers, per byte b: b, x2=xtime(b), x4=xtime(x2), x8=xtime(x4), plus the inv and bypass bits and v1.
  - xtime(b) = (b<<1) ^ (b[7] ? 8'h1B : 0), truncated to 8 bits.
  - Stage 2 registers out_data, computed from stage 1:
    - forward matrix rows 02 03 01 01 / 01 02 03 01 / 01 01 02 03 / 03 01 01 02, with 03 = x2^b;
    - inverse matrix rows 0E 0B 0D 09 / 09 0E 0B 0D / 0D 09 0E 0B / 0B 0D 09 0E;
    - 09 = x8^b, 0B = x8^x2^b, 0D = x8^x4^b, 0E = x8^x4^x2;
    - bypass: output = stored b unchanged.
  - All columns are processed independently and identically; there is no inter-column mixing.
- Handshake: advance = ~out_valid | out_ready; in_ready = advance (combinational).
  - When advance=1: stage 2 loads from stage 1 (v2 <= v1), and stage 1 loads from the input (v1 <= in_valid).
  - When advance=0: both stages hold their contents; out_data is stable while out_valid=1 and out_ready=0.
- Throughput is one beat per cycle when out_ready is held high.
- Input and output transfer in the same cycle: both happen. This includes the full-pipeline case, which gives no bubble.
- in_data, in_inv and in_bypass are sampled only on the handshake (in_valid & in_ready); they are don't-care otherwise.
- out_data retains its last value when out_valid=0 and is not cleared on drain.
- busy = v1 | v2.
- Mode is per beat: interleaved forward, inverse and bypass beats must each produce the correct result for their own mode.
- in_valid may be held high while in_ready=0; the beat is taken on the first cycle with in_ready=1. No beat is lost or duplicated.
- Reset asserted mid-stream: outputs drop on the reset edge. The first beat accepted after reset release emerges 2 cycles later.

Test Plan:
1. NCOL=1, forward, in_data=32'hdb135345 -> 2 cycles later out_data=32'h8e4da1bc. Also: f20a225c -> 9fdc589d, 01010101 -> 01010101, c6c6c6c6 -> c6c6c6c6.
2. NCOL=1, inverse: 8e4da1bc -> db135345 and 9fdc589d -> f20a225c. Random round-trip check: inverse(forward(x)) == x for 1000 random words.
3. NCOL=4, forward, in_data=128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5 -> out_data=128'h046681e5_e0cb199a_48f8d37a_2806264c. Same beat with in_bypass=1 -> output equals input.
4. Backpressure: stream 6 beats with alternating modes and out_ready toggling randomly. Required: in_ready==out_ready whenever out_valid=1; out_data stable while stalled; all 6 results arrive in order, each correct for its mode.
5. Full streaming: in_valid and out_ready held high for 8 beats. Required: 8 outputs on consecutive cycles, starting 2 cycles after the first accept.
6. Reset: assert rst asynchronously with 2 beats in flight. Required: out_valid=0, busy=0 and out_data=0 before the next clk edge. After release, one beat dbl3 (db135345, forward) -> 8e4da1bc after 2 cycles, with no stale outputs.

Source files
------------

// File: rtl/mix_columns_if.sv
// Valid/ready stream bundle for the MixColumns pipeline.
// The slave modport is the engine side, the master modport is the driver side.
interface mix_columns_if #(
    parameter int NCOL = 4
);
    localparam int W = 32 * NCOL;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_inv;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid, in_data, in_inv, in_bypass, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, in_inv, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mix_columns_pipe.sv
// Two-stage MixColumns / InvMixColumns / bypass engine, NCOL columns per beat.
// Stage 1 holds each byte with its xtime multiples; stage 2 holds the mixed state.
module mix_columns_pipe #(
    parameter int NCOL = 4
) (
    input  logic          clk,
    input  logic          rst,
    mix_columns_if.slave  bus
);
    localparam int W  = 32 * NCOL;
    localparam int NB = 4 * NCOL;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    logic         advance;
    logic         v1;
    logic         v2;
    logic         inv1;
    logic         byp1;
    logic [W-1:0] out_q;
    logic [W-1:0] mix_next;

    logic [7:0] in_b  [NB];
    logic [7:0] in_x2 [NB];
    logic [7:0] in_x4 [NB];
    logic [7:0] in_x8 [NB];
    logic [7:0] b1    [NB];
    logic [7:0] x2_1  [NB];
    logic [7:0] x4_1  [NB];
    logic [7:0] x8_1  [NB];
    logic [7:0] mix_b [NB];

    assign advance       = ~v2 | bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = v2;
    assign bus.out_data  = out_q;
    assign bus.busy      = v1 | v2;

    // Byte k is column k/4, row k%4; column 0 sits in the top 32 bits.
    for (genvar k = 0; k < NB; k++) begin : g_byte
        assign in_b[k]  = bus.in_data[W-1-8*k -: 8];
        assign in_x2[k] = xtime(in_b[k]);
        assign in_x4[k] = xtime(in_x2[k]);
        assign in_x8[k] = xtime(in_x4[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            inv1 <= 1'b0;
            byp1 <= 1'b0;
            for (int k = 0; k < NB; k++) begin
                b1[k]   <= 8'h00;
                x2_1[k] <= 8'h00;
                x4_1[k] <= 8'h00;
                x8_1[k] <= 8'h00;
            end
        end else if (advance) begin
            v1 <= bus.in_valid;
            if (bus.in_valid) begin
                inv1 <= bus.in_inv;
                byp1 <= bus.in_bypass;
                for (int k = 0; k < NB; k++) begin
                    b1[k]   <= in_b[k];
                    x2_1[k] <= in_x2[k];
                    x4_1[k] <= in_x4[k];
                    x8_1[k] <= in_x8[k];
                end
            end
        end
    end

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int K0 = 4 * c + r;
            localparam int K1 = 4 * c + (r + 1) % 4;
            localparam int K2 = 4 * c + (r + 2) % 4;
            localparam int K3 = 4 * c + (r + 3) % 4;
            logic [7:0] fwd_byte;
            logic [7:0] inv_byte;

            // 02.a0 ^ 03.a1 ^ a2 ^ a3 and 0E.a0 ^ 0B.a1 ^ 0D.a2 ^ 09.a3, rotated per row
            assign fwd_byte = x2_1[K0] ^ x2_1[K1] ^ b1[K1] ^ b1[K2] ^ b1[K3];
            assign inv_byte = (x8_1[K0] ^ x4_1[K0] ^ x2_1[K0])
                            ^ (x8_1[K1] ^ x2_1[K1] ^ b1[K1])
                            ^ (x8_1[K2] ^ x4_1[K2] ^ b1[K2])
                            ^ (x8_1[K3] ^ b1[K3]);
            assign mix_b[K0] = byp1 ? b1[K0] : (inv1 ? inv_byte : fwd_byte);
        end
    end

    always_comb begin
        mix_next = '0;
        for (int k = 0; k < NB; k++) begin
            mix_next[W-1-8*k -: 8] = mix_b[k];
        end
    end

    // out_q only loads real beats so it keeps its last value across drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            out_q <= '0;
        end else if (advance) begin
            v2 <= v1;
            if (v1) begin
                out_q <= mix_next;
            end
        end
    end
endmodule

// File: tb/tb_mix_columns_pipe.sv
// Scoreboard bench for mix_columns_pipe at NCOL=1 and NCOL=4.
// Expected results come from a generic GF(2^8) multiply model.
module tb_mix_columns_pipe;
    typedef struct {
        logic [127:0] d;
        bit           inv;
        bit           byp;
    } beat_t;

    logic clk;
    logic rst;

    mix_columns_if #(.NCOL(4)) b4 ();
    mix_columns_if #(.NCOL(1)) b1 ();

    mix_columns_pipe #(.NCOL(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    mix_columns_pipe #(.NCOL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int viol_ready;
    int viol_stable;

    beat_t        src1 [$];
    beat_t        src4 [$];
    logic [31:0]  got1 [$];
    logic [31:0]  exp1 [$];
    logic [127:0] got4 [$];
    logic [127:0] exp4 [$];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1B;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int d);
        case (d)
            0:       return inv ? 8'h0E : 8'h02;
            1:       return inv ? 8'h0B : 8'h03;
            2:       return inv ? 8'h0D : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [31:0] model_col(input logic [31:0] w, input bit inv);
        logic [31:0] r = '0;
        logic [7:0]  acc;
        for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
                acc = acc ^ gmul(coef(inv, (j - i + 4) % 4), w[31-8*j -: 8]);
            r[31-8*i -: 8] = acc;
        end
        return r;
    endfunction

    function automatic logic [127:0] model4(input logic [127:0] d, input bit inv, input bit byp);
        logic [127:0] r = '0;
        if (byp) return d;
        for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(d[127-32*c -: 32], inv);
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stream drivers: feed the source queue and collect outputs; comparisons live in the tests.
    task automatic run1(input int budget);
        int n   = src1.size();
        int cyc = 0;
        got1.delete();
        b1.out_ready = 1'b1;
        while (got1.size() < n && cyc < budget) begin
            @(posedge clk); #1;
            if (src1.size() > 0) begin
                b1.in_valid  = 1'b1;
                b1.in_data   = src1[0].d[31:0];
                b1.in_inv    = src1[0].inv;
                b1.in_bypass = src1[0].byp;
            end else begin
                b1.in_valid = 1'b0;
                b1.in_data  = $urandom();
            end
            @(negedge clk);
            if (b1.out_valid && b1.out_ready) got1.push_back(b1.out_data);
            if (b1.in_valid && b1.in_ready) void'(src1.pop_front());
            cyc++;
        end
        b1.in_valid = 1'b0;
    endtask

    task automatic run4(input int budget, input bit rand_ready);
        int           n       = src4.size();
        int           cyc     = 0;
        bit           stalled = 0;
        logic [127:0] last_data = '0;
        got4.delete();
        viol_ready  = 0;
        viol_stable = 0;
        while (got4.size() < n && cyc < budget) begin
            @(posedge clk); #1;
            b4.out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (src4.size() > 0) begin
                b4.in_valid  = 1'b1;
                b4.in_data   = src4[0].d;
                b4.in_inv    = src4[0].inv;
                b4.in_bypass = src4[0].byp;
            end else begin
                b4.in_valid = 1'b0;
                b4.in_data  = rand128();
            end
            @(negedge clk);
            if (stalled && (!b4.out_valid || b4.out_data !== last_data)) viol_stable++;
            if (b4.out_valid && (b4.in_ready !== b4.out_ready)) viol_ready++;
            stalled   = b4.out_valid && !b4.out_ready;
            last_data = b4.out_data;
            if (b4.out_valid && b4.out_ready) got4.push_back(b4.out_data);
            if (b4.in_valid && b4.in_ready) void'(src4.pop_front());
            cyc++;
        end
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        n_total++; if (b4.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", b4.out_valid); else n_pass++;
        n_total++; if (b4.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", b4.busy); else n_pass++;
        n_total++; if (b4.out_data !== 128'h0) $display("FAIL reset_out_data got=%h want=0", b4.out_data); else n_pass++;
        n_total++; if (b4.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", b4.in_ready); else n_pass++;
        n_total++; if (b1.out_valid !== 1'b0) $display("FAIL reset1_out_valid got=%b want=0", b1.out_valid); else n_pass++;
        n_total++; if (b1.in_ready !== 1'b1) $display("FAIL reset1_in_ready got=%b want=1", b1.in_ready); else n_pass++;
    endtask

    task automatic test_ncol1_vectors();
        logic [31:0] vin  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc, 32'h9fdc589d};
        logic [31:0] vout [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345, 32'hf20a225c};
        logic [31:0] e;
        exp1.delete();
        for (int i = 0; i < 6; i++) begin
            src1.push_back('{d: {96'h0, vin[i]}, inv: (i >= 4), byp: 1'b0});
            exp1.push_back(vout[i]);
        end
        run1(100);
        n_total++; if (got1.size() != 6) $display("FAIL ncol1_vec_count got=%0d want=6", got1.size()); else n_pass++;
        foreach (got1[i]) begin
            e = (exp1.size() > 0) ? exp1.pop_front() : 'x;
            n_total++; if (got1[i] !== e) $display("FAIL ncol1_vec[%0d] got=%h want=%h", i, got1[i], e); else n_pass++;
        end
    endtask

    task automatic test_ncol1_roundtrip();
        logic [31:0] x [1000];
        logic [31:0] y [1000];
        logic [31:0] e;
        exp1.delete();
        for (int i = 0; i < 1000; i++) begin
            x[i] = $urandom();
            y[i] = 32'h0;
            src1.push_back('{d: {96'h0, x[i]}, inv: 1'b0, byp: 1'b0});
            exp1.push_back(model_col(x[i], 1'b0));
        end
        run1(3000);
        n_total++; if (got1.size() != 1000) $display("FAIL rt_fwd_count got=%0d want=1000", got1.size()); else n_pass++;
        foreach (got1[i]) begin
            y[i] = got1[i];
            e = (exp1.size() > 0) ? exp1.pop_front() : 'x;
            n_total++; if (got1[i] !== e) $display("FAIL rt_fwd[%0d] got=%h want=%h", i, got1[i], e); else n_pass++;
        end
        exp1.delete();
        for (int i = 0; i < 1000; i++) begin
            src1.push_back('{d: {96'h0, y[i]}, inv: 1'b1, byp: 1'b0});
            exp1.push_back(x[i]);
        end
        run1(3000);
        n_total++; if (got1.size() != 1000) $display("FAIL rt_inv_count got=%0d want=1000", got1.size()); else n_pass++;
        foreach (got1[i]) begin
            e = (exp1.size() > 0) ? exp1.pop_front() : 'x;
            n_total++; if (got1[i] !== e) $display("FAIL rt_inv[%0d] got=%h want=%h", i, got1[i], e); else n_pass++;
        end
    endtask

    task automatic test_ncol4_vectors();
        logic [127:0] vin  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
        logic [127:0] vout = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
        logic [127:0] d;
        logic [127:0] e;
        bit           inv;
        bit           byp;
        exp4.delete();
        src4.push_back('{d: vin, inv: 1'b0, byp: 1'b0});  exp4.push_back(vout);
        src4.push_back('{d: vin, inv: 1'b0, byp: 1'b1});  exp4.push_back(vin);
        src4.push_back('{d: vin, inv: 1'b1, byp: 1'b1});  exp4.push_back(vin);
        src4.push_back('{d: vout, inv: 1'b1, byp: 1'b0}); exp4.push_back(vin);
        for (int i = 0; i < 20; i++) begin
            d   = rand128();
            inv = ($urandom_range(0, 1) == 1);
            byp = ($urandom_range(0, 3) == 0);
            src4.push_back('{d: d, inv: inv, byp: byp});
            exp4.push_back(model4(d, inv, byp));
        end
        run4(200, 1'b0);
        n_total++; if (got4.size() != 24) $display("FAIL ncol4_count got=%0d want=24", got4.size()); else n_pass++;
        foreach (got4[i]) begin
            e = (exp4.size() > 0) ? exp4.pop_front() : 'x;
            n_total++; if (got4[i] !== e) $display("FAIL ncol4[%0d] got=%h want=%h", i, got4[i], e); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        logic [127:0] e;
        exp4.delete();
        for (int i = 0; i < 6; i++) begin
            d = rand128();
            src4.push_back('{d: d, inv: (i % 3 == 1), byp: (i % 3 == 2)});
            exp4.push_back(model4(d, (i % 3 == 1), (i % 3 == 2)));
        end
        run4(300, 1'b1);
        n_total++; if (viol_ready != 0) $display("FAIL bp_in_ready_eq_out_ready violations=%0d want=0", viol_ready); else n_pass++;
        n_total++; if (viol_stable != 0) $display("FAIL bp_stall_stable violations=%0d want=0", viol_stable); else n_pass++;
        n_total++; if (got4.size() != 6) $display("FAIL bp_count got=%0d want=6", got4.size()); else n_pass++;
        foreach (got4[i]) begin
            e = (exp4.size() > 0) ? exp4.pop_front() : 'x;
            n_total++; if (got4[i] !== e) $display("FAIL bp[%0d] got=%h want=%h", i, got4[i], e); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int           cyc = 0;
        int           sent = 0;
        int           n_out = 0;
        int           first_acc = -1;
        int           first_out = -1;
        int           last_out = -1;
        int           gaps = 0;
        logic [127:0] e;
        exp4.delete();
        b4.out_ready = 1'b1;
        while (n_out < 8 && cyc < 50) begin
            @(posedge clk); #1;
            if (sent < 8) begin
                b4.in_valid  = 1'b1;
                b4.in_data   = rand128();
                b4.in_inv    = (sent % 2 == 1);
                b4.in_bypass = 1'b0;
            end else begin
                b4.in_valid = 1'b0;
            end
            @(negedge clk);
            if (b4.out_valid) begin
                if (first_out < 0) first_out = cyc;
                else if (cyc != last_out + 1) gaps++;
                last_out = cyc;
                e = (exp4.size() > 0) ? exp4.pop_front() : 'x;
                n_total++; if (b4.out_data !== e) $display("FAIL b2b_data[%0d] got=%h want=%h", n_out, b4.out_data, e); else n_pass++;
                n_out++;
            end
            if (b4.in_valid && b4.in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                exp4.push_back(model4(b4.in_data, b4.in_inv, b4.in_bypass));
                sent++;
            end
            cyc++;
        end
        b4.in_valid = 1'b0;
        n_total++; if (n_out != 8) $display("FAIL b2b_count got=%0d want=8", n_out); else n_pass++;
        n_total++; if (first_out != first_acc + 2) $display("FAIL b2b_latency got=%0d want=%0d", first_out, first_acc + 2); else n_pass++;
        n_total++; if (gaps != 0) $display("FAIL b2b_gaps got=%0d want=0", gaps); else n_pass++;
    endtask

    task automatic test_async_reset();
        int           cyc = 0;
        int           acc = -1;
        int           outc = -1;
        int           n_out = 0;
        logic [127:0] want = {4{32'h8e4da1bc}};
        b4.out_ready = 1'b1;
        @(posedge clk); #1;
        b4.in_valid  = 1'b1;
        b4.in_data   = rand128();
        b4.in_inv    = 1'b0;
        b4.in_bypass = 1'b0;
        @(posedge clk); #1;
        b4.in_data = rand128();
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        n_total++; if (b4.busy !== 1'b1 || b4.out_valid !== 1'b1) $display("FAIL rst_pre_inflight busy=%b out_valid=%b want=1,1", b4.busy, b4.out_valid); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (b4.out_valid !== 1'b0) $display("FAIL rst_async_out_valid got=%b want=0", b4.out_valid); else n_pass++;
        n_total++; if (b4.busy !== 1'b0) $display("FAIL rst_async_busy got=%b want=0", b4.busy); else n_pass++;
        n_total++; if (b4.out_data !== 128'h0) $display("FAIL rst_async_out_data got=%h want=0", b4.out_data); else n_pass++;
        @(negedge clk);
        @(negedge clk); #2 rst = 1'b0;
        n_total++; if (b4.in_ready !== 1'b1) $display("FAIL rst_release_in_ready got=%b want=1", b4.in_ready); else n_pass++;
        while (cyc < 10) begin
            @(posedge clk); #1;
            if (acc < 0) begin
                b4.in_valid  = 1'b1;
                b4.in_data   = {4{32'hdb135345}};
                b4.in_inv    = 1'b0;
                b4.in_bypass = 1'b0;
            end else begin
                b4.in_valid = 1'b0;
            end
            @(negedge clk);
            if (b4.out_valid) begin
                if (outc < 0) outc = cyc;
                n_out++;
                n_total++; if (b4.out_data !== want) $display("FAIL rst_after_data got=%h want=%h", b4.out_data, want); else n_pass++;
            end
            if (b4.in_valid && b4.in_ready && acc < 0) acc = cyc;
            cyc++;
        end
        b4.in_valid = 1'b0;
        n_total++; if (n_out != 1) $display("FAIL rst_after_count got=%0d want=1", n_out); else n_pass++;
        n_total++; if (outc != acc + 2) $display("FAIL rst_after_latency got=%0d want=%0d", outc, acc + 2); else n_pass++;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_inv = 1'b0; b4.in_bypass = 1'b0; b4.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_inv = 1'b0; b1.in_bypass = 1'b0; b1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_ncol1_vectors();
        test_ncol1_roundtrip();
        test_ncol4_vectors();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
